// File: rtl/rx_dma_pkg.sv
// Shared RX DMA definitions: RX RAM pointer width, TLP/page limits,
// trigger FSM state encoding and the wrapped pointer difference helper.
package rx_dma_pkg;

    localparam int RX_RAM_AW      = 9;
    localparam int MAX_TLP_QWORDS = 16;
    localparam int PAGE_QWORDS    = 262144;
    localparam int TIMEOUT_CYCLES = 256;
    localparam int PAGE_CNT_W     = 18;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        COMMIT = 2'd2
    } trig_state_t;

    // Pointers carry a wrap bit above the qword address, so a plain
    // modulo-1024 subtraction gives the fill level across the RAM boundary.
    function automatic logic [RX_RAM_AW:0] ptr_diff(input logic [RX_RAM_AW:0] wr,
                                                    input logic [RX_RAM_AW:0] rd);
        return wr - rd;
    endfunction

endpackage

// File: rtl/rx_tlp_trigger_if.sv
// Request handshake between the TLP trigger and the RX DMA engine.
// Handshake: a request (trigger_tlp or change_huge_page) is raised together
// with qwords_to_send and send_last_tlp_change_huge_page, and all of them are
// held stable until the engine returns the matching ack; the request drops
// in the cycle after that ack is sampled high.
interface rx_tlp_trigger_if;

    logic       trigger_tlp;
    logic       trigger_tlp_ack;
    logic       change_huge_page;
    logic       change_huge_page_ack;
    logic       send_last_tlp_change_huge_page;
    logic [4:0] qwords_to_send;

    modport master (
        output trigger_tlp,
        output change_huge_page,
        output send_last_tlp_change_huge_page,
        output qwords_to_send,
        input  trigger_tlp_ack,
        input  change_huge_page_ack
    );

    modport slave (
        input  trigger_tlp,
        input  change_huge_page,
        input  send_last_tlp_change_huge_page,
        input  qwords_to_send,
        output trigger_tlp_ack,
        output change_huge_page_ack
    );

endinterface

// File: rtl/rx_tlp_timeout_cnt.sv
// Idle timer for partial-TLP flushing; exists only when
// TLP_TRIGGER_TIMEOUT_EN is defined. Counts while armed, restarts whenever
// the write pointer moves, and saturates at TIMEOUT_CYCLES-1.
`ifdef TLP_TRIGGER_TIMEOUT_EN
module rx_tlp_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = rx_dma_pkg::TIMEOUT_CYCLES,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [9:0] i_wr_ptr,
    input  logic       i_arm,
    output logic       o_expired
);

    logic [CNT_W-1:0] r_cnt;
    logic [9:0]       r_wr_prev;
    logic             w_expired;

    assign w_expired = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign o_expired = w_expired;

    // Count idle cycles; any write-pointer movement or disarm restarts it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_wr_prev <= '0;
        end else begin
            r_wr_prev <= i_wr_ptr;
            if (!i_arm || (i_wr_ptr != r_wr_prev)) begin
                r_cnt <= '0;
            end else if (!w_expired) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/rx_tlp_trigger.sv
// RX TLP trigger: decides when the RX DMA engine emits a memory-write TLP
// and how many qwords it carries, closing the huge page when it fills.
// Optional: define TLP_TRIGGER_TIMEOUT_EN to delay partial TLPs until the
// write pointer has been idle for TIMEOUT_CYCLES; otherwise partial TLPs
// are requested immediately.
module rx_tlp_trigger #(
    parameter int PAGE_QWORDS    = rx_dma_pkg::PAGE_QWORDS,
    parameter int MAX_TLP_QWORDS = rx_dma_pkg::MAX_TLP_QWORDS
`ifdef TLP_TRIGGER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = rx_dma_pkg::TIMEOUT_CYCLES
`endif
) (
    input  logic                    trn_clk,
    input  logic                    trn_reset_n,
    input  logic [9:0]              commited_wr_address,
    input  logic [9:0]              commited_rd_address,
    output rx_dma_pkg::trig_state_t o_state,
    rx_tlp_trigger_if.master        bus
);
    import rx_dma_pkg::*;

    localparam logic [18:0] PAGE_Q = 19'(PAGE_QWORDS);
    localparam logic [9:0]  MAX_Q  = 10'(MAX_TLP_QWORDS);

    trig_state_t            r_state;
    logic [9:0]             r_avail;
    logic [PAGE_CNT_W-1:0]  r_page_cnt;
    logic [9:0]             r_rd_snap;
    logic                   r_trigger;
    logic                   r_change;
    logic                   r_send_last;
    logic [4:0]             r_qwords;

    logic [18:0]            w_page_left;
    logic [18:0]            w_lim;
    logic [18:0]            w_n_full;
    logic [4:0]             w_n;
    logic                   w_closes;
    logic                   w_full;
    logic                   w_partial;
    logic                   w_flush;
    logic                   w_go;

    // Register the fill level once per cycle from the two committed pointers.
    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            r_avail <= '0;
        end else begin
            r_avail <= ptr_diff(commited_wr_address, commited_rd_address);
        end
    end

    // Payload size: smallest of fill level, TLP limit and room left in the page.
    always_comb begin
        w_page_left = PAGE_Q - {1'b0, r_page_cnt};
        w_lim       = (r_avail < MAX_Q) ? {9'd0, r_avail} : {9'd0, MAX_Q};
        w_n_full    = (w_lim < w_page_left) ? w_lim : w_page_left;
        w_n         = w_n_full[4:0];
        w_closes    = (w_n_full == w_page_left);
        w_full      = (r_avail >= MAX_Q);
        w_partial   = (r_avail != 10'd0) && (r_avail < MAX_Q);
        w_go        = w_full || (w_partial && w_flush);
    end

`ifdef TLP_TRIGGER_TIMEOUT_EN
    rx_tlp_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (trn_clk),
        .i_rst_n   (trn_reset_n),
        .i_wr_ptr  (commited_wr_address),
        .i_arm     ((r_state == IDLE) && w_partial),
        .o_expired (w_flush)
    );
`else
    assign w_flush = 1'b1;
`endif

    // Trigger FSM: raise a request, hold it until its own ack, then wait for
    // the read pointer to move so a stale fill level cannot re-trigger.
    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            r_state     <= IDLE;
            r_page_cnt  <= '0;
            r_rd_snap   <= '0;
            r_trigger   <= 1'b0;
            r_change    <= 1'b0;
            r_send_last <= 1'b0;
            r_qwords    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_state  <= REQ;
                        r_qwords <= w_n;
                        if (w_closes) begin
                            r_change    <= 1'b1;
                            r_send_last <= 1'b1;
                        end else begin
                            r_trigger <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (r_trigger && bus.trigger_tlp_ack) begin
                        r_trigger  <= 1'b0;
                        r_page_cnt <= r_page_cnt + PAGE_CNT_W'(r_qwords);
                        r_rd_snap  <= commited_rd_address;
                        r_state    <= COMMIT;
                    end else if (r_change && bus.change_huge_page_ack) begin
                        r_change    <= 1'b0;
                        r_send_last <= 1'b0;
                        r_page_cnt  <= '0;
                        r_rd_snap   <= commited_rd_address;
                        r_state     <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (commited_rd_address != r_rd_snap) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.trigger_tlp                    = r_trigger;
    assign bus.change_huge_page               = r_change;
    assign bus.send_last_tlp_change_huge_page = r_send_last;
    assign bus.qwords_to_send                 = r_qwords;
    assign o_state                            = r_state;

endmodule

// File: tb/tb_rx_tlp_trigger.sv
// Directed bench for rx_tlp_trigger with a small page (40 qwords) so the
// page-close path is reachable; expected requests are queued as pointers
// are driven and popped when the DUT raises a request.
module tb_rx_tlp_trigger;
    import rx_dma_pkg::*;

    localparam int PAGE = 40;
    localparam int MAXQ = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  wr;
    logic [9:0]  rd;
    trig_state_t st;

    rx_tlp_trigger_if u_if();

    rx_tlp_trigger #(
        .PAGE_QWORDS    (PAGE),
        .MAX_TLP_QWORDS (MAXQ)
    ) dut (
        .trn_clk             (clk),
        .trn_reset_n         (rst_n),
        .commited_wr_address (wr),
        .commited_rd_address (rd),
        .o_state             (st),
        .bus                 (u_if)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no_finish required=finish");
        $fatal(1, "watchdog expired");
    end

    int         n_total    = 0;
    int         n_bad      = 0;
    int         model_page = 0;
    logic       last_kind  = 1'b0;
    logic [4:0] last_n     = '0;
    logic [5:0] exp_q[$];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Model of the next request for a given fill level: {close_page, qwords}.
    function automatic void push_expect(input int avail);
        int   n;
        logic k;
        n = avail;
        if (n > MAXQ) n = MAXQ;
        if (n > PAGE - model_page) n = PAGE - model_page;
        k = (model_page + n == PAGE);
        exp_q.push_back({k, 5'(n)});
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        wr = '0;
        rd = '0;
        u_if.trigger_tlp_ack = 1'b0;
        u_if.change_huge_page_ack = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        model_page = 0;
        tick();
    endtask

    task automatic expect_req(input string tag, input int budget);
        int         waited;
        logic [5:0] e;
        waited = 0;
        while (!(u_if.trigger_tlp || u_if.change_huge_page) && waited < budget) begin
            tick();
            waited++;
        end
        chk({tag, "_seen"}, 32'(u_if.trigger_tlp || u_if.change_huge_page), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            last_kind = e[5];
            last_n    = e[4:0];
            chk({tag, "_trigger"},   32'(u_if.trigger_tlp), 32'(!e[5]));
            chk({tag, "_change"},    32'(u_if.change_huge_page), 32'(e[5]));
            chk({tag, "_send_last"}, 32'(u_if.send_last_tlp_change_huge_page), 32'(e[5]));
            chk({tag, "_qwords"},    32'(u_if.qwords_to_send), 32'(e[4:0]));
        end
    endtask

    task automatic ack_req(input string tag);
        if (last_kind) u_if.change_huge_page_ack = 1'b1;
        else           u_if.trigger_tlp_ack = 1'b1;
        tick();
        u_if.trigger_tlp_ack = 1'b0;
        u_if.change_huge_page_ack = 1'b0;
        chk({tag, "_trig_drop"}, 32'(u_if.trigger_tlp), 32'd0);
        chk({tag, "_chg_drop"},  32'(u_if.change_huge_page), 32'd0);
        chk({tag, "_commit"},    32'(st), 32'(COMMIT));
        model_page = last_kind ? 0 : model_page + int'(last_n);
    endtask

    initial begin
        logic seen;
        logic stable;

        // reset state
        rst_n = 1'b0;
        wr = '0;
        rd = '0;
        u_if.trigger_tlp_ack = 1'b0;
        u_if.change_huge_page_ack = 1'b0;
        repeat (2) tick();
        chk("rst_trigger",   32'(u_if.trigger_tlp), 32'd0);
        chk("rst_change",    32'(u_if.change_huge_page), 32'd0);
        chk("rst_send_last", 32'(u_if.send_last_tlp_change_huge_page), 32'd0);
        chk("rst_qwords",    32'(u_if.qwords_to_send), 32'd0);
        chk("rst_state",     32'(st), 32'(IDLE));
        rst_n = 1'b1;
        tick();

        // full TLP with exact two-cycle latency
        wr = 10'h010;
        rd = 10'h000;
        push_expect(16);
        tick();
        chk("t1_early", 32'(u_if.trigger_tlp), 32'd0);
        tick();
        expect_req("t1_full", 0);
        ack_req("t1_ack");
        rd = 10'h010;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (u_if.trigger_tlp || u_if.change_huge_page) seen = 1'b1;
        end
        chk("t1_no_second", 32'(seen), 32'd0);
        chk("t1_idle", 32'(st), 32'(IDLE));

        // wrap-around: 0x205 - 0x1FA = 11
        do_reset();
        wr = 10'h205;
        rd = 10'h1FA;
        push_expect(11);
`ifdef TLP_TRIGGER_TIMEOUT_EN
        seen = 1'b0;
        repeat (200) begin
            tick();
            if (u_if.trigger_tlp || u_if.change_huge_page) seen = 1'b1;
        end
        chk("t2_no_early", 32'(seen), 32'd0);
        expect_req("t2_wrap", 120);
`else
        expect_req("t2_wrap", 4);
`endif
        ack_req("t2_ack");
        rd = 10'h205;
        repeat (4) tick();
        chk("t2_idle", 32'(st), 32'(IDLE));

`ifdef TLP_TRIGGER_TIMEOUT_EN
        // timeout restarts on write-pointer movement
        do_reset();
        wr = 10'h005;
        seen = 1'b0;
        repeat (200) begin
            tick();
            if (u_if.trigger_tlp || u_if.change_huge_page) seen = 1'b1;
        end
        wr = 10'h006;
        push_expect(6);
        repeat (200) begin
            tick();
            if (u_if.trigger_tlp || u_if.change_huge_page) seen = 1'b1;
        end
        chk("t3_no_early", 32'(seen), 32'd0);
        expect_req("t3_timeout", 120);
        ack_req("t3_ack");
        rd = 10'h006;
        repeat (4) tick();
`endif

        // page close: 16 + 16 + 8 (close), then a new page of 16
        do_reset();
        wr = 10'h030;
        push_expect(48);
        expect_req("t4_r1", 6);
        ack_req("t4_r1_ack");
        rd = 10'h010;
        push_expect(32);
        expect_req("t4_r2", 6);
        ack_req("t4_r2_ack");
        rd = 10'h020;
        push_expect(16);
        expect_req("t4_close", 6);
        ack_req("t4_close_ack");
        wr = 10'h040;
        rd = 10'h028;
        push_expect(24);
        expect_req("t4_newpage", 6);

        // ack discipline on the pending 16-qword request
        stable = 1'b1;
        repeat (50) begin
            tick();
            if (!(u_if.trigger_tlp === 1'b1 && u_if.qwords_to_send === last_n)) stable = 1'b0;
        end
        chk("t5_hold_stable", 32'(stable), 32'd1);
        u_if.change_huge_page_ack = 1'b1;
        tick();
        u_if.change_huge_page_ack = 1'b0;
        chk("t5_wrong_ack_trigger", 32'(u_if.trigger_tlp), 32'd1);
        chk("t5_wrong_ack_state",   32'(st), 32'(REQ));
        u_if.change_huge_page_ack = 1'b1;
        u_if.trigger_tlp_ack = 1'b1;
        tick();
        u_if.change_huge_page_ack = 1'b0;
        u_if.trigger_tlp_ack = 1'b0;
        chk("t5_both_trigger", 32'(u_if.trigger_tlp), 32'd0);
        chk("t5_both_change",  32'(u_if.change_huge_page), 32'd0);
        chk("t5_both_state",   32'(st), 32'(COMMIT));
        model_page = model_page + int'(last_n);
        rd = 10'h040;
        repeat (4) tick();
        chk("t5_idle", 32'(st), 32'(IDLE));

        // asynchronous reset while a request is pending
        do_reset();
        wr = 10'h030;
        push_expect(48);
        expect_req("t6_r1", 6);
        ack_req("t6_r1_ack");
        rd = 10'h010;
        push_expect(32);
        expect_req("t6_r2", 6);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_trigger", 32'(u_if.trigger_tlp), 32'd0);
        chk("t6_async_qwords",  32'(u_if.qwords_to_send), 32'd0);
        chk("t6_async_state",   32'(st), 32'(IDLE));
        model_page = 0;
        tick();
        rst_n = 1'b1;
        push_expect(32);
        expect_req("t6_post_r1", 6);
        ack_req("t6_post_r1_ack");
        rd = 10'h020;
        push_expect(16);
        expect_req("t6_post_r2", 6);
        ack_req("t6_post_r2_ack");
        rd = 10'h030;
        repeat (4) tick();
        chk("t6_idle", 32'(st), 32'(IDLE));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
